// File: rtl/stack_control_unit_pkg.sv
// Shared types and encodings for the stack machine sequencer: FSM states,
// opcodes, stack/ALU operation codes and the decoded-instruction bundle.
package stack_control_unit_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_LIT   = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_PUSHI = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_SUB   = 4'h3;
  localparam logic [3:0] OP_OR    = 4'h4;
  localparam logic [3:0] OP_DUP   = 4'h5;
  localparam logic [3:0] OP_DROP  = 4'h6;
  localparam logic [3:0] OP_OVER  = 4'h7;
  localparam logic [3:0] OP_SLT   = 4'h8;
  localparam logic [3:0] OP_SWAP  = 4'h9;
  localparam logic [3:0] OP_BEQ   = 4'hA;
  localparam logic [3:0] OP_BEZ   = 4'hB;
  localparam logic [3:0] OP_JMP   = 4'hC;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [2:0] SOP_NOP  = 3'd0;
  localparam logic [2:0] SOP_PUSH = 3'd1;
  localparam logic [2:0] SOP_ALU  = 3'd2;
  localparam logic [2:0] SOP_DROP = 3'd3;
  localparam logic [2:0] SOP_CMP  = 3'd4;
  localparam logic [2:0] SOP_SWAP = 3'd5;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_PASSA = 4'd5;
  localparam logic [3:0] ALU_PASSB = 4'd6;
  localparam logic [3:0] ALU_EQ    = 4'd7;
  localparam logic [3:0] ALU_ZERO  = 4'd8;
  localparam logic [3:0] ALU_SLT   = 4'd9;

  typedef struct packed {
    logic [2:0] stack_op;
    logic [3:0] alu_op;
    logic       mux_sel;
    logic       is_pushi;
    logic       is_branch;
    logic       is_jump;
    logic       is_halt;
    logic       illegal;
  } decode_t;

  localparam decode_t DEC_NONE = '{
    stack_op:  SOP_NOP,
    alu_op:    ALU_ADD,
    mux_sel:   1'b0,
    is_pushi:  1'b0,
    is_branch: 1'b0,
    is_jump:   1'b0,
    is_halt:   1'b0,
    illegal:   1'b0
  };

  function automatic logic pc_redirect(input decode_t dec, input logic cond);
    return dec.is_jump | (dec.is_branch & cond);
  endfunction

endpackage

// File: rtl/stack_control_unit_decode.sv
// Combinational opcode decoder: maps a 4-bit opcode onto datapath controls
// and the sequencing flags used by the fetch FSM.
module stack_control_unit_decode
  import stack_control_unit_pkg::*;
(
  input  logic [3:0] opcode,
  output decode_t    dec
);

  // Opcode table; unknown opcodes decode as a datapath no-op flagged illegal.
  always_comb begin
    dec = DEC_NONE;
    case (opcode)
      OP_NOP:   dec = DEC_NONE;
      OP_PUSHI: begin dec.stack_op = SOP_PUSH; dec.mux_sel = 1'b1; dec.is_pushi = 1'b1; end
      OP_ADD:   begin dec.stack_op = SOP_ALU;  dec.alu_op = ALU_ADD;   end
      OP_SUB:   begin dec.stack_op = SOP_ALU;  dec.alu_op = ALU_SUB;   end
      OP_OR:    begin dec.stack_op = SOP_ALU;  dec.alu_op = ALU_OR;    end
      OP_SLT:   begin dec.stack_op = SOP_ALU;  dec.alu_op = ALU_SLT;   end
      OP_DUP:   begin dec.stack_op = SOP_PUSH; dec.alu_op = ALU_PASSA; end
      OP_OVER:  begin dec.stack_op = SOP_PUSH; dec.alu_op = ALU_PASSB; end
      OP_DROP:  dec.stack_op = SOP_DROP;
      OP_SWAP:  dec.stack_op = SOP_SWAP;
      OP_BEQ:   begin dec.stack_op = SOP_CMP; dec.alu_op = ALU_EQ;   dec.is_branch = 1'b1; end
      OP_BEZ:   begin dec.stack_op = SOP_CMP; dec.alu_op = ALU_ZERO; dec.is_branch = 1'b1; end
      OP_JMP:   dec.is_jump = 1'b1;
      OP_HALT:  dec.is_halt = 1'b1;
      default:  dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/stack_control_unit.sv
// Fetch/decode/sequencing stage for the push/pop stack datapath: holds PC,
// instruction and literal registers and drives one EXEC cycle per instruction.
module stack_control_unit
  import stack_control_unit_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              run,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_req,
  input  logic              imem_valid,
  input  logic [15:0]       imem_data,
  input  logic [15:0]       ALU_out,
  input  logic              Overflow,
  output logic [2:0]        stackOP,
  output logic [3:0]        aluOP,
  output logic              mux_selector,
  output logic [15:0]       immediate,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              fault
);

  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  state_t            state_r;
  logic [ADDR_W-1:0] pc_r;
  logic [15:0]       ir_r;
  logic [15:0]       imm_r;
  logic              halted_r;
  logic              fault_r;
  decode_t           exec_dec_r;

  logic [3:0]        dec_op_s;
  decode_t           dec_s;
  logic              fire_s;
  logic              fetching_s;
  logic [ADDR_W-1:0] target_s;
  logic              unused_bits_s;

  // In LIT the held instruction is decoded; in FETCH the incoming word is.
  assign dec_op_s   = (state_r == ST_LIT) ? ir_r[15:12] : imem_data[15:12];
  assign fetching_s = (state_r == ST_FETCH) || (state_r == ST_LIT);
  assign fire_s     = fetching_s & run & imem_valid;
  assign target_s   = ir_r[ADDR_W-1:0];

  assign unused_bits_s = ^{ALU_out[15:1], exec_dec_r.is_pushi};

  stack_control_unit_decode u_decode (
    .opcode (dec_op_s),
    .dec    (dec_s)
  );

  // Sequencer FSM with PC, IR, literal and the registered EXEC controls.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_FETCH;
      pc_r       <= '0;
      ir_r       <= 16'h0000;
      imm_r      <= 16'h0000;
      halted_r   <= 1'b0;
      fault_r    <= 1'b0;
      exec_dec_r <= DEC_NONE;
    end else begin
      exec_dec_r <= DEC_NONE;
      case (state_r)
        ST_FETCH: begin
          if (fire_s) begin
            ir_r <= imem_data;
            pc_r <= pc_r + PC_ONE;
            if (dec_s.is_pushi) begin
              state_r <= ST_LIT;
            end else begin
              state_r    <= ST_EXEC;
              exec_dec_r <= dec_s;
            end
          end else begin
            state_r <= ST_FETCH;
          end
        end
        ST_LIT: begin
          if (fire_s) begin
            imm_r      <= imem_data;
            pc_r       <= pc_r + PC_ONE;
            state_r    <= ST_EXEC;
            exec_dec_r <= dec_s;
          end else begin
            state_r <= ST_LIT;
          end
        end
        ST_EXEC: begin
          // Overflow outranks everything, including a pending branch.
          if (Overflow) begin
            state_r  <= ST_HALT;
            halted_r <= 1'b1;
            fault_r  <= 1'b1;
          end else if (exec_dec_r.is_halt || exec_dec_r.illegal) begin
            state_r  <= ST_HALT;
            halted_r <= 1'b1;
            fault_r  <= exec_dec_r.illegal;
          end else begin
            state_r <= ST_FETCH;
            if (pc_redirect(exec_dec_r, ALU_out[0])) begin
              pc_r <= target_s;
            end else begin
              pc_r <= pc_r;
            end
          end
        end
        ST_HALT: begin
          state_r  <= ST_HALT;
          halted_r <= 1'b1;
        end
        default: begin
          state_r  <= ST_HALT;
          halted_r <= 1'b1;
          fault_r  <= 1'b1;
        end
      endcase
    end
  end

  assign imem_req     = fetching_s & run;
  assign imem_addr    = pc_r;
  assign pc           = pc_r;
  assign immediate    = imm_r;
  assign halted       = halted_r;
  assign fault        = fault_r;
  assign stackOP      = exec_dec_r.stack_op;
  assign aluOP        = exec_dec_r.alu_op;
  assign mux_selector = exec_dec_r.mux_sel;

endmodule

// File: tb/tb_stack_control_unit.sv
// Directed bench: array-backed instruction memory with wait states and a
// small behavioural stack datapath closing the ALU_out/Overflow loop.
module tb_stack_control_unit;

  logic        CLK = 1'b0;
  logic        reset, run, imem_valid, Overflow;
  logic [15:0] imem_data, ALU_out;
  logic [11:0] imem_addr, pc;
  logic        imem_req, mux_selector, halted, fault;
  logic [2:0]  stackOP;
  logic [3:0]  aluOP;
  logic [15:0] immediate;

  logic        run4, valid4, req4, mux4, halted4, fault4;
  logic        ov4 = 1'b0;
  logic [15:0] data4, imm4;
  logic [15:0] alu4 = 16'h0000;
  logic [3:0]  addr4, pc4, aluop4;
  logic [2:0]  sop4;

  logic [15:0] mem  [0:63];
  logic [15:0] mem4 [0:15];
  logic [15:0] stk  [0:15];
  int          ws, wcnt, sp, pulses;
  logic        saw_addr2, ov_arm, found;
  logic [15:0] a, b, r;
  int          tests, failed;

  always #5 CLK = ~CLK;

  stack_control_unit #(.ADDR_W(12)) dut (
    .CLK(CLK), .reset(reset), .run(run), .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_valid(imem_valid), .imem_data(imem_data), .ALU_out(ALU_out), .Overflow(Overflow),
    .stackOP(stackOP), .aluOP(aluOP), .mux_selector(mux_selector), .immediate(immediate),
    .pc(pc), .halted(halted), .fault(fault)
  );

  stack_control_unit #(.ADDR_W(4)) dut4 (
    .CLK(CLK), .reset(reset), .run(run4), .imem_addr(addr4), .imem_req(req4),
    .imem_valid(valid4), .imem_data(data4), .ALU_out(alu4), .Overflow(ov4),
    .stackOP(sop4), .aluOP(aluop4), .mux_selector(mux4), .immediate(imm4),
    .pc(pc4), .halted(halted4), .fault(fault4)
  );

  // Instruction memory with ws wait states per access.
  always @(negedge CLK) begin
    if (!reset) begin
      wcnt = 0;
      imem_valid = 1'b0;
      imem_data = 16'hDEAD;
    end else if (imem_req) begin
      if (imem_addr == 12'd2) saw_addr2 = 1'b1;
      if (wcnt >= ws) begin
        imem_valid = 1'b1;
        imem_data = mem[imem_addr[5:0]];
        wcnt = 0;
      end else begin
        imem_valid = 1'b0;
        imem_data = 16'hDEAD;
        wcnt++;
      end
    end else begin
      imem_valid = 1'b0;
      imem_data = 16'hDEAD;
    end
  end

  // Zero-wait memory for the narrow-PC instance.
  always @(negedge CLK) begin
    valid4 = req4;
    data4 = mem4[addr4];
  end

  // Stack datapath model: ALU result from the pre-op stack, then apply op.
  always @(negedge CLK) begin
    if (reset) begin
      a = (sp > 0) ? stk[sp-1] : 16'h0000;
      b = (sp > 1) ? stk[sp-2] : 16'h0000;
      case (aluOP)
        4'd0: r = b + a;
        4'd1: r = b - a;
        4'd3: r = b | a;
        4'd5: r = a;
        4'd6: r = b;
        4'd7: r = (a == b) ? 16'h0001 : 16'h0000;
        4'd8: r = (a == 16'h0000) ? 16'h0001 : 16'h0000;
        4'd9: r = ($signed(b) < $signed(a)) ? 16'h0001 : 16'h0000;
        default: r = 16'h0000;
      endcase
      ALU_out = r;
      if (stackOP != 3'd0) pulses++;
      if (ov_arm && stackOP == 3'd1) Overflow = 1'b1;
      case (stackOP)
        3'd1: if (sp < 16) begin stk[sp] = mux_selector ? immediate : r; sp++; end
        3'd2: if (sp >= 2) begin sp = sp - 2; stk[sp] = r; sp++; end
        3'd3: if (sp > 0) sp--;
        3'd5: if (sp >= 2) begin stk[sp-1] = b; stk[sp-2] = a; end
        default: ;
      endcase
    end
  end

  function automatic logic [15:0] tos();
    return (sp > 0) ? stk[sp-1] : 16'h0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load8(input logic [15:0] w0, w1, w2, w3, w4, w5, w6, w7);
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    mem[0] = w0; mem[1] = w1; mem[2] = w2; mem[3] = w3;
    mem[4] = w4; mem[5] = w5; mem[6] = w6; mem[7] = w7;
  endtask

  task automatic do_reset();
    reset = 1'b0; run = 1'b0; run4 = 1'b0; Overflow = 1'b0; ov_arm = 1'b0;
    ALU_out = 16'h0000; sp = 0; pulses = 0; saw_addr2 = 1'b0;
    repeat (2) @(negedge CLK);
    reset = 1'b1;
  endtask

  task automatic wait_halt(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (halted) break;
      @(negedge CLK);
    end
  endtask

  initial begin
    tests = 0; failed = 0; ws = 0;
    for (int i = 0; i < 16; i++) mem4[i] = 16'h0000;
    load8(16'h1000, 16'h0002, 16'h1000, 16'h0005, 16'h2000, 16'hF000, 16'h0000, 16'h0000);
    do_reset();
    repeat (3) @(negedge CLK);
    chk("rst_pc", pc, 12'd0);
    chk("rst_addr", imem_addr, 12'd0);
    chk("rst_req_idle", imem_req, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_stackop", stackOP, 3'd0);
    chk("rst_imm", immediate, 16'h0000);

    // 1: 2 + 5 -> 7
    run = 1'b1;
    wait_halt(100);
    chk("p1_halted", halted, 1'b1);
    chk("p1_fault", fault, 1'b0);
    chk("p1_pc", pc, 12'd6);
    chk("p1_tos", tos(), 16'd7);
    chk("p1_imm", immediate, 16'd5);
    chk("p1_pulses", pulses, 3);
    chk("p1_req_off", imem_req, 1'b0);

    // 2: BEQ to 5 taken / not taken
    load8(16'h1000, 16'h0004, 16'h1000, 16'h0004, 16'hA005, 16'h1000, 16'h0009, 16'hF000);
    do_reset(); run = 1'b1; wait_halt(100);
    chk("p2a_pc", pc, 12'd8);
    chk("p2a_tos", tos(), 16'd9);
    chk("p2a_fault", fault, 1'b0);
    load8(16'h1000, 16'h0004, 16'h1000, 16'h0003, 16'hA005, 16'h1000, 16'h0009, 16'hF000);
    do_reset(); run = 1'b1; wait_halt(100);
    chk("p2b_pc", pc, 12'd8);
    chk("p2b_tos", tos(), 16'd9);
    // BEQ to 7 skips the second push only when taken
    load8(16'h1000, 16'h0004, 16'h1000, 16'h0004, 16'hA007, 16'h1000, 16'h0009, 16'hF000);
    do_reset(); run = 1'b1; wait_halt(100);
    chk("p2c_tos", tos(), 16'd4);
    chk("p2c_pulses", pulses, 3);
    load8(16'h1000, 16'h0004, 16'h1000, 16'h0003, 16'hA007, 16'h1000, 16'h0009, 16'hF000);
    do_reset(); run = 1'b1; wait_halt(100);
    chk("p2d_tos", tos(), 16'd9);
    chk("p2d_pulses", pulses, 4);

    // 3: BEZ
    load8(16'h1000, 16'h0000, 16'hB003, 16'h1000, 16'h0001, 16'hF000, 16'h0000, 16'h0000);
    do_reset(); run = 1'b1; wait_halt(100);
    chk("p3_halted", halted, 1'b1);
    chk("p3_pc", pc, 12'd6);
    chk("p3_tos", tos(), 16'd1);

    // 4: illegal opcode
    load8(16'hD000, 16'h1000, 16'h0001, 16'hF000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    do_reset(); run = 1'b1; wait_halt(50);
    chk("p4_halted", halted, 1'b1);
    chk("p4_fault", fault, 1'b1);
    chk("p4_pc", pc, 12'd1);
    chk("p4_pulses", pulses, 0);

    // 5: Overflow during PUSHI EXEC
    load8(16'h1000, 16'h0007, 16'hC000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    do_reset(); ov_arm = 1'b1; run = 1'b1; wait_halt(50);
    chk("p5_halted", halted, 1'b1);
    chk("p5_fault", fault, 1'b1);
    chk("p5_pc", pc, 12'd2);
    chk("p5_no_jmp_fetch", saw_addr2, 1'b0);

    // 6a: wait states plus run=0 for 4 cycles in LIT
    ws = 3;
    load8(16'h1000, 16'h0002, 16'h1000, 16'h0005, 16'h2000, 16'hF000, 16'h0000, 16'h0000);
    do_reset(); run = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (imem_req && imem_addr == 12'd1) begin found = 1'b1; break; end
    end
    chk("p6_lit_seen", found, 1'b1);
    run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("p6_stall_req", imem_req, 1'b0);
      chk("p6_stall_addr", imem_addr, 12'd1);
    end
    run = 1'b1;
    wait_halt(300);
    chk("p6_tos", tos(), 16'd7);
    chk("p6_pulses", pulses, 3);
    chk("p6_pc", pc, 12'd6);
    ws = 0;

    // 6b: ADDR_W=4, PUSHI at 15 reads its literal from 0
    mem4[0] = 16'hC00F; mem4[1] = 16'hF000; mem4[15] = 16'h1000;
    do_reset(); run4 = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (halted4) break;
      @(negedge CLK);
    end
    chk("p6w_halted", halted4, 1'b1);
    chk("p6w_imm", imm4, 16'hC00F);
    chk("p6w_pc", pc4, 4'd2);
    chk("p6w_fault", fault4, 1'b0);

    // 6c: async reset during EXEC
    load8(16'h1000, 16'h0002, 16'h1000, 16'h0005, 16'h2000, 16'hF000, 16'h0000, 16'h0000);
    do_reset(); run = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (stackOP != 3'd0) begin found = 1'b1; break; end
    end
    chk("p6r_exec_seen", found, 1'b1);
    #1 reset = 1'b0;
    #1;
    chk("p6r_stackop", stackOP, 3'd0);
    chk("p6r_aluop", aluOP, 4'd0);
    chk("p6r_mux", mux_selector, 1'b0);
    chk("p6r_pc", pc, 12'd0);
    chk("p6r_imm", immediate, 16'h0000);
    chk("p6r_halted", halted, 1'b0);
    chk("p6r_fault", fault, 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
